// File: rtl/dffram_obi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dffram_obi_bridge: arbitrates Ibex instr/data OBI ports onto one DFFRAM.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dffram_obi_bridge #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [31:0]       ram_di_o,
  output logic [ADDR_W-1:0] ram_a_o,
  input  logic [31:0]       ram_do_i
);

  logic instr_hit, data_hit, conflict;
  logic last_q;
  logic instr_rvalid_q, instr_err_q, instr_rd_q;
  logic data_rvalid_q, data_err_q, data_rd_q;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  assign instr_hit = (instr_addr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign data_hit  = (data_addr_i[31:ADDR_W+2]  == BASE_ADDR[31:ADDR_W+2]);
  assign conflict  = instr_req_i & data_req_i;

  // last_q names the port granted at the previous conflict; the other one wins now
  assign data_gnt_o  = data_req_i  & (~instr_req_i | ~last_q);
  assign instr_gnt_o = instr_req_i & (~data_req_i  |  last_q);

  always_comb begin
    ram_a_o  = data_addr_i[ADDR_W+1:2];
    ram_di_o = data_wdata_i;
    ram_en_o = 1'b0;
    ram_we_o = 4'b0000;
    if (instr_gnt_o) begin
      ram_a_o  = instr_addr_i[ADDR_W+1:2];
      ram_en_o = instr_hit;
    end else if (data_gnt_o) begin
      ram_en_o = data_hit;
      ram_we_o = (data_hit & data_we_i) ? data_be_i : 4'b0000;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_q         <= 1'b0;
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      instr_rd_q     <= 1'b0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;
      data_rd_q      <= 1'b0;
    end else begin
      if (conflict) begin
        last_q <= data_gnt_o;
      end
      instr_rvalid_q <= instr_gnt_o;
      instr_err_q    <= instr_gnt_o & ~instr_hit;
      instr_rd_q     <= instr_gnt_o & instr_hit;
      data_rvalid_q  <= data_gnt_o;
      data_err_q     <= data_gnt_o & ~data_hit;
      data_rd_q      <= data_gnt_o & data_hit & ~data_we_i;
    end
  end

  // DO is only meaningful for the read that was granted last cycle
  assign instr_rvalid_o = instr_rvalid_q;
  assign instr_err_o    = instr_rvalid_q & instr_err_q;
  assign instr_rdata_o  = (instr_rvalid_q & instr_rd_q) ? ram_do_i : 32'h0;
  assign data_rvalid_o  = data_rvalid_q;
  assign data_err_o     = data_rvalid_q & data_err_q;
  assign data_rdata_o   = (data_rvalid_q & data_rd_q) ? ram_do_i : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dffram_obi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dffram_obi_bridge: scoreboard bench with a behavioural DFFRAM model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dffram_obi_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic        instr_req_i, data_req_i, data_we_i;
  logic [31:0] instr_addr_i, data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_di_o;
  logic [11:0] ram_a_o;
  logic [31:0] ram_do_i;

  typedef struct packed {
    int unsigned c;
    logic [32:0] v;
  } ent_t;

  ent_t        iq[$];
  ent_t        dq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc_cnt = 0;
  logic [31:0] mem [0:4095];

  always #5 CLK = ~CLK;

  dffram_obi_bridge #(.ADDR_W(12), .BASE_ADDR(32'h0)) dut (
    .CLK(CLK), .RST(RST),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_di_o(ram_di_o), .ram_a_o(ram_a_o),
    .ram_do_i(ram_do_i)
  );

  // DFFRAM model: byte-masked write, registered read
  initial begin
    ram_do_i = 32'h0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  end
  always @(posedge CLK) begin
    if (ram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_we_o[b]) mem[ram_a_o][8*b +: 8] <= ram_di_o[8*b +: 8];
      if (ram_we_o == 4'b0000) ram_do_i <= mem[ram_a_o];
    end
  end

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : monitor
    ent_t e;
    if (instr_rvalid_o) begin
      if (iq.size() == 0) check("instr_unexpected_rvalid", 64'd1, 64'd0);
      else begin
        e = iq.pop_front();
        check("instr_latency", 64'(cyc_cnt), 64'(e.c));
        check("instr_resp", {31'h0, instr_err_o, instr_rdata_o}, {31'h0, e.v});
      end
    end
    if (data_rvalid_o) begin
      if (dq.size() == 0) check("data_unexpected_rvalid", 64'd1, 64'd0);
      else begin
        e = dq.pop_front();
        check("data_latency", 64'(cyc_cnt), 64'(e.c));
        check("data_resp", {31'h0, data_err_o, data_rdata_o}, {31'h0, e.v});
      end
    end
  end

  // One bus cycle: drive, check grant/RAM strobes, queue expected responses ({err,rdata})
  task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                     input logic [1:0] eg, input logic een, input logic [3:0] ewe,
                     input logic [32:0] iexp, input logic [32:0] dexp);
    ent_t e;
    @(posedge CLK);
    #1;
    instr_req_i = ir; instr_addr_i = ia;
    data_req_i = dr; data_we_i = dw; data_be_i = be; data_addr_i = da; data_wdata_i = wd;
    #2;
    check("gnt_id", {62'h0, instr_gnt_o, data_gnt_o}, {62'h0, eg});
    check("ram_en", {63'h0, ram_en_o}, {63'h0, een});
    check("ram_we", {60'h0, ram_we_o}, {60'h0, ewe});
    if (eg[1]) begin e.c = cyc_cnt + 1; e.v = iexp; iq.push_back(e); end
    if (eg[0]) begin e.c = cyc_cnt + 1; e.v = dexp; dq.push_back(e); end
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 1'b0, 4'h0, 33'h0, 33'h0);
  endtask

  logic [31:0] w0, w1, wv;

  initial begin
    RST = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    #3;
    check("reset_outs", {28'h0, instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o, instr_rdata_o | data_rdata_o},
          64'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // full write then instr read of the same word on the next cycle
    cyc(0, 32'h0, 1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 2'b01, 1, 4'hF, 33'h0, 33'h0);
    cyc(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0, 2'b10, 1, 4'h0, {1'b0, 32'hDEADBEEF}, 33'h0);
    // byte-masked write, then a be=0 no-op write, then read back
    cyc(0, 32'h0, 1, 1, 4'hF, 32'h20, 32'hFFFFFFFF, 2'b01, 1, 4'hF, 33'h0, 33'h0);
    cyc(0, 32'h0, 1, 1, 4'b0101, 32'h20, 32'h11223344, 2'b01, 1, 4'b0101, 33'h0, 33'h0);
    cyc(0, 32'h0, 1, 1, 4'h0, 32'h22, 32'h0, 2'b01, 1, 4'h0, 33'h0, 33'h0);
    cyc(0, 32'h0, 1, 0, 4'h0, 32'h23, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, 32'hFF22FF44});

    // preload words 0..7, then read them back-to-back
    for (int i = 0; i < 8; i++) begin
      wv = 32'hA5000000 + i * 32'h00010203;
      cyc(0, 32'h0, 1, 1, 4'hF, i * 4, wv, 2'b01, 1, 4'hF, 33'h0, 33'h0);
    end
    for (int i = 0; i < 8; i++) begin
      wv = 32'hA5000000 + i * 32'h00010203;
      cyc(0, 32'h0, 1, 0, 4'h0, i * 4, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, wv});
    end

    // continuous contention: data first after reset, then alternating
    w0 = 32'hA5000000;
    w1 = 32'hA5010203;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        cyc(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, w1});
      else
        cyc(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0, 2'b10, 1, 4'h0, {1'b0, w0}, 33'h0);
    end
    cyc(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, w1});

    // out-of-range accesses never touch the RAM
    cyc(0, 32'h0, 1, 0, 4'h0, 32'h0001_0000, 32'h0, 2'b01, 0, 4'h0, 33'h0, {1'b1, 32'h0});
    cyc(1, 32'hFFFF_FFF0, 0, 0, 4'h0, 32'h0, 32'h0, 2'b10, 0, 4'h0, {1'b1, 32'h0}, 33'h0);
    cyc(0, 32'h0, 1, 1, 4'hF, 32'h0000_4000, 32'h12345678, 2'b01, 0, 4'h0, 33'h0, {1'b1, 32'h0});
    cyc(0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, w0});

    // reset between grant and response drops the response and clears last_q
    idle();
    cyc(0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, w0});
    #1;
    RST = 1'b1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_drop_rvalid", {62'h0, instr_rvalid_o, data_rvalid_o}, 64'h0);
    iq.delete();
    dq.delete();
    RST = 1'b0;
    cyc(1, 32'h4, 1, 0, 4'h0, 32'h0, 32'h0, 2'b01, 1, 4'h0, 33'h0, {1'b0, w0});
    cyc(1, 32'h4, 1, 0, 4'h0, 32'h0, 32'h0, 2'b10, 1, 4'h0, {1'b0, w1}, 33'h0);

    idle();
    idle();
    check("queues_drained", 64'(iq.size() + dq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dffram_obi_bridge.md
# dffram_obi_bridge

Initiator-side bridge that drives the single-port DFFRAM macro (EN / WE[3:0] / DI / DO / A) on behalf of the Ibex core's instruction and data buses. It accepts OBI-style req/gnt/rvalid transactions from both ports and arbitrates them onto the one RAM port. It tracks the RAM's one-cycle read latency and returns rdata/rvalid, or an error for addresses outside the RAM window. It sits between the core and the DFFRAM instance in the memory subsystem.

## Interface
- ADDR_W, 12, RAM word-address width; must match the DFFRAM A width (2^ADDR_W 32-bit words)
- BASE_ADDR, 32'h0000_0000, byte base of the RAM window; aligned to 2^(ADDR_W+2)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- instr_req_i  in  1  instruction fetch request (read only)
- instr_addr_i  in  32  byte address
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid
- instr_rdata_o  out  32  read data
- instr_err_o  out  1  error response (qualified by rvalid)
- data_req_i  in  1  load/store request
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_gnt_o, data_rvalid_o, data_rdata_o[31:0], data_err_o  out  as for the instruction port
- ram_en_o  out  1  to DFFRAM EN
- ram_we_o  out  4  to DFFRAM WE
- ram_di_o  out  32  to DFFRAM DI
- ram_a_o  out  ADDR_W  to DFFRAM A
- ram_do_i  in  32  from DFFRAM DO (registered in the RAM)

## Operation
- The RAM port accepts one access per cycle, so a granted port is granted combinationally in the same cycle as its req.
- Arbitration:
  - A single requester is always granted.
  - On conflict, round-robin via register last_q (0 = instr, 1 = data): the port not granted last wins. last_q updates only on a conflict grant.
- In range: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. Word address: ram_a_o = addr[ADDR_W+1:2]; addr[1:0] is ignored.
- Granted in-range read: ram_en_o=1, ram_we_o=0.
- Granted in-range write: ram_en_o=1, ram_we_o=data_be_i, ram_di_o=data_wdata_i.
  - be=0 is a legal no-op write; it still produces a response.
- Granted out-of-range access:
  - ram_en_o=0, so the RAM is not touched.
  - The response carries err=1 and rdata=0.
- No grant: ram_en_o=0, ram_we_o=0. ram_a_o and ram_di_o are don't-care but driven from the data port.
- The instruction port never writes; ram_we_o is 0 for any instruction grant.
- Response registers, one set per port:
  - rvalid_q: set one cycle after a grant, cleared otherwise.
  - err_q: out-of-range flag.
  - rd_q: access was an in-range read.
- Outputs:
  - rvalid_o = rvalid_q; err_o = rvalid_q & err_q.
  - rdata_o = ram_do_i when rvalid_q & rd_q, else 0.
  - Write responses return rdata=0 and discard the stale DO.
- No outstanding-request limit is needed: each response arrives in the cycle after its grant, before the RAM can produce another.

## Timing
- Reset (async assert): all rvalid_q/err_q/rd_q = 0; last_q = 0, so the data port wins the first conflict.
  - Output values in reset: rvalid_o=0, err_o=0, rdata_o=0, gnt_o driven only by req.
  - Combinational RAM outputs follow the inputs; the core holds req low in reset.
- Latency: grant in cycle N, then rvalid/rdata/err in cycle N+1, for reads, writes and errors alike.
- Throughput: one access per cycle in total. Back-to-back grants on one port give back-to-back rvalids.
- Loser of an arbitration keeps req and addr stable and is granted in the next cycle by round-robin.
  - Worst-case wait is 1 cycle under continuous contention.
- A write to address X in cycle N followed by a read of X in cycle N+1 returns the new data in N+2.
- Reset asserted between grant and response: the pending response is dropped and no rvalid is produced.

## Test plan
- Data write: addr=0x10, be=4'hF, wdata=0xDEADBEEF. Then an instr read of 0x10 on the next cycle → instr_rvalid at N+2 with 0xDEADBEEF; the data write response has rdata=0 and err=0.
- Byte-mask write: be=4'b0101, wdata=0x11223344 over 0xFFFFFFFF, then read → 0xFF22FF44.
- Both ports request every cycle for 6 cycles → grants alternate data, instr, data…; each rvalid follows its gnt by exactly 1 cycle; ram_en_o=1 every cycle.
- Out-of-range read at 0x0001_0000 (BASE=0, ADDR_W=12) → gnt same cycle, ram_en_o=0, and next cycle rvalid=1, err=1, rdata=0.
- Back-to-back reads of words 0 to 7 on the data port → 8 consecutive rvalids with correct data and no bubbles.
- RST pulsed in the cycle after a grant → no rvalid is emitted; last_q = 0, so the next conflict is granted to data.
